// File: rtl/sweep_ctrl.sv
// sweep_ctrl: linear frequency sweep sequencer for a downstream triangle DDS.
// Steps fre from f_start toward f_stop, holding each value for max(dwell,1) cycles.
module sweep_ctrl #(
  parameter int DW = 24
) (
  input  logic          clk_100M,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic [24:0]   f_start,
  input  logic [24:0]   f_stop,
  input  logic [24:0]   f_step,
  input  logic [DW-1:0] dwell,
  input  logic          repeat_en,
  input  logic          prst_en,
  output logic [24:0]   fre,
  output logic          phase_rst,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, RUN, WRAP} state_t;

  state_t        state_q;
  logic [24:0]   fre_q;
  logic [24:0]   fstart_q;
  logic [24:0]   fstop_q;
  logic [24:0]   fstep_q;
  logic [DW-1:0] cnt_q;
  logic [DW-1:0] hold_q;
  logic          rep_q;
  logic          prst_q;
  logic          down_q;
  logic          last_q;
  logic          busy_q;
  logic          done_q;
  logic          phase_rst_q;

  logic [DW-1:0] hold_d;
  logic          first_last_d;
  logic          wrap_last_d;
  logic [25:0]   up_sum_d;
  logic [25:0]   dn_diff_d;
  logic [24:0]   step_d;

  assign fre       = fre_q;
  assign phase_rst = phase_rst_q;
  assign busy      = busy_q;
  assign done      = done_q;

  // hold_* is the reload value of the down-counter: D-1 with D = max(dwell,1)
  always_comb begin
    hold_d       = (dwell == '0) ? '0 : dwell - DW'(1);
    first_last_d = (f_step == '0) || (f_start == f_stop);
    wrap_last_d  = (fstep_q == '0) || (fstart_q == fstop_q);
    up_sum_d     = {1'b0, fre_q} + {1'b0, fstep_q};
    dn_diff_d    = {1'b0, fre_q} - {1'b0, fstep_q};
    step_d       = up_sum_d[24:0];
    if (down_q) begin
      // a borrow out means the step went below zero, so it certainly passed f_stop
      if (dn_diff_d[25] || (dn_diff_d <= {1'b0, fstop_q})) begin
        step_d = fstop_q;
      end else begin
        step_d = dn_diff_d[24:0];
      end
    end else if (up_sum_d >= {1'b0, fstop_q}) begin
      step_d = fstop_q;
    end
  end

  always_ff @(posedge clk_100M) begin
    if (rst) begin
      state_q     <= IDLE;
      fre_q       <= '0;
      cnt_q       <= '0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      phase_rst_q <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      phase_rst_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start && !stop) begin
            fstart_q    <= f_start;
            fstop_q     <= f_stop;
            fstep_q     <= f_step;
            hold_q      <= hold_d;
            rep_q       <= repeat_en;
            prst_q      <= prst_en;
            down_q      <= (f_start > f_stop);
            fre_q       <= f_start;
            cnt_q       <= hold_d;
            last_q      <= first_last_d;
            busy_q      <= 1'b1;
            phase_rst_q <= prst_en;
            state_q     <= RUN;
          end
        end
        RUN, WRAP: begin
          if (stop) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (cnt_q != '0) begin
            cnt_q   <= cnt_q - DW'(1);
            state_q <= RUN;
          end else if (!last_q) begin
            fre_q   <= step_d;
            last_q  <= (step_d == fstop_q);
            cnt_q   <= hold_q;
            state_q <= RUN;
          end else if (rep_q) begin
            // WRAP reloads the first frequency on the same cycle as the done pulse
            done_q      <= 1'b1;
            fre_q       <= fstart_q;
            phase_rst_q <= prst_q;
            cnt_q       <= hold_q;
            last_q      <= wrap_last_d;
            state_q     <= WRAP;
          end else begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/sweep_ctrl.md
SWEEP_CTRL -- requirements
Module: sweep_ctrl

Interface
REQ-001 Parameter DW, default 24, width of the dwell-count input.
REQ-002 clk_100M  input  1  system clock, 100 MHz; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  sweep start request, sampled each cycle.
REQ-005 stop  input  1  sweep abort request, sampled each cycle.
REQ-006 f_start  input  25  first frequency word, Hz, unsigned.
REQ-007 f_stop  input  25  last frequency word, Hz, unsigned.
REQ-008 f_step  input  25  frequency increment magnitude, Hz, unsigned.
REQ-009 dwell  input  DW  clock cycles each frequency is held.
REQ-010 repeat_en  input  1  1 = restart sweep after completion; 0 = single sweep.
REQ-011 prst_en  input  1  1 = pulse phase_rst at each sweep (re)start.
REQ-012 fre  output  25  frequency word to the downstream triangle DDS fre input.
REQ-013 phase_rst  output  1  one-cycle phase reset to the downstream DDS.
REQ-014 busy  output  1  high while a sweep is in progress.
REQ-015 done  output  1  one-cycle pulse at each completed sweep pass.

Function
REQ-016 States: IDLE, RUN, WRAP; all outputs registered.
REQ-017 IDLE: start=1 and stop=0 at edge N latches f_start, f_stop, f_step, dwell, repeat_en, prst_en; at edge N+1 fre=f_start, busy=1, phase_rst=prst_en, state RUN.
REQ-018 Inputs other than start/stop are ignored outside the IDLE latch cycle; start is ignored while busy=1.
REQ-019 Direction: up if latched f_start <= f_stop, else down.
REQ-020 Effective dwell D = max(dwell, 1); every frequency value is held on fre for exactly D cycles.
REQ-021 Step: next = fre +/- f_step computed in 26 bits; if next passes or equals f_stop, next = f_stop (clamp, no overshoot, no wrap).
REQ-022 f_step = 0 or f_start = f_stop: sweep consists of f_start only, held D cycles, then completion.
REQ-023 Completion (f_stop dwell expired), repeat_en=0: next cycle done=1 for one cycle, busy=0, fre holds f_stop, state IDLE.
REQ-024 Completion, repeat_en=1: next cycle done=1, state WRAP passes immediately so fre=f_start and phase_rst=prst_en on that same cycle; busy stays 1.
REQ-025 phase_rst is never high for more than one consecutive cycle and only coincides with fre loading f_start.
REQ-026 stop=1 in RUN/WRAP: next cycle busy=0, done=0, phase_rst=0, fre holds current value, state IDLE.
REQ-027 stop and start both high in IDLE: stop wins, no sweep starts.
REQ-028 stop and completion in the same cycle: stop wins, done not asserted.
REQ-029 Dwell counter width DW; no counter may overflow for dwell = 2^DW-1.

Reset
REQ-030 rst=1 at a rising edge forces state IDLE, fre=0, phase_rst=0, busy=0, done=0, counters 0.
REQ-031 rst overrides start/stop; reset mid-sweep aborts with no done pulse.
REQ-032 First start accepted on the edge after rst deasserts.

Verification
REQ-033 f_start=1000, f_stop=1300, f_step=100, dwell=3, repeat_en=0, prst_en=1, start pulse -> fre 1000,1100,1200,1300 each 3 cycles; phase_rst high on first 1000 cycle only; done one cycle after last 1300; busy 12 cycles.
REQ-034 f_start=5000, f_stop=4750, f_step=100, dwell=2 -> fre 5000,4900,4800,4750 each 2 cycles (down, clamped), then done.
REQ-035 f_start=f_stop=2000 or f_step=0, dwell=0 -> fre=2000 for 1 cycle, done next cycle, busy=0.
REQ-036 repeat_en=1, f_start=10, f_stop=30, f_step=10, dwell=1, prst_en=1 -> 10,20,30,10,20,30...; done and phase_rst coincide with every return to 10.
REQ-037 stop asserted mid-sweep at fre=1100 -> next cycle busy=0, fre=1100 held, no done; new start then restarts at f_start.
REQ-038 rst asserted mid-sweep, and start+stop together in IDLE -> all outputs 0 after rst; no sweep started for simultaneous start/stop.
